// File: rtl/xc_malu_mdr_seq.sv
// Iterative multiply / divide / remainder unit with its own operand, counter and accumulator state.
// Optional early-out path for trivial operands is enabled by defining XC_MALU_MDR_EARLY_OUT_EN.
module xc_malu_mdr_seq #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned MUL_BPC = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                flush,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [3:0]          req_op,
    input  logic [XLEN-1:0]     req_rs1,
    input  logic [XLEN-1:0]     req_rs2,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [XLEN-1:0]     rsp_result,
    output logic [2*XLEN-1:0]   rsp_wide,
    output logic                busy
);

    localparam int unsigned MUL_ITERS = XLEN / MUL_BPC;
    localparam int unsigned CW        = $clog2(XLEN + 1);

    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

    state_t              state_q, state_d;
    logic [3:0]          op_q;
    logic                neg_q;
    logic [CW-1:0]       count_q;
    logic [2*XLEN-1:0]   mcand_q, acc_q;
    logic [XLEN-1:0]     mplier_q, quo_q, dvsr_q;
    logic [XLEN:0]       rem_q;
    logic [XLEN-1:0]     result_q;
    logic [2*XLEN-1:0]   wide_q;

    logic                accept, op_is_mul, op_is_div;
    logic                s1, s2, rs1_sgn, rs2_sgn, neg_d;
    logic [XLEN-1:0]     mag1, mag2;
    logic                early_hit;
    logic [XLEN-1:0]     early_res;

    assign s1        = req_rs1[XLEN-1];
    assign s2        = req_rs2[XLEN-1];
    assign op_is_mul = (req_op < 4'd6);
    assign op_is_div = (req_op[3:2] == 2'b10);
    assign accept    = req_valid && req_ready;

    always_comb begin
        rs1_sgn = 1'b0;
        rs2_sgn = 1'b0;
        neg_d   = 1'b0;
        case (req_op)
            4'd1:  begin rs1_sgn = 1'b1; rs2_sgn = 1'b1; neg_d = s1 ^ s2; end
            4'd2:  begin rs1_sgn = 1'b1; neg_d = s1; end
            4'd8:  begin rs1_sgn = 1'b1; rs2_sgn = 1'b1; neg_d = (s1 ^ s2) && (req_rs2 != '0); end
            4'd10: begin rs1_sgn = 1'b1; rs2_sgn = 1'b1; neg_d = s1; end
            default: ;
        endcase
    end

    assign mag1 = (rs1_sgn && s1) ? -req_rs1 : req_rs1;
    assign mag2 = (rs2_sgn && s2) ? -req_rs2 : req_rs2;

`ifdef XC_MALU_MDR_EARLY_OUT_EN
    // rem/remu (op bit 1 set) return rs1 unchanged for both zero divisor and oversized divisor.
    always_comb begin
        early_hit = 1'b0;
        early_res = '0;
        if (op_is_mul && (req_rs1 == '0 || req_rs2 == '0)) begin
            early_hit = 1'b1;
        end else if (op_is_div && (mag2 == '0 || mag2 > mag1)) begin
            early_hit = 1'b1;
            if (req_op[1])
                early_res = req_rs1;
            else if (mag2 == '0)
                early_res = '1;
        end
    end
`else
    assign early_hit = 1'b0;
    assign early_res = '0;
`endif

    logic                mul_clmul;
    logic [2*XLEN-1:0]   mul_sum;

    assign mul_clmul = (op_q[3:1] == 3'b010);

    always_comb begin
        mul_sum = acc_q;
        for (int unsigned j = 0; j < MUL_BPC; j++) begin
            if (mplier_q[j])
                mul_sum = mul_clmul ? (mul_sum ^ (mcand_q << j)) : (mul_sum + (mcand_q << j));
        end
    end

    // Shift includes the spare remainder bit so the trial subtract sees the whole register.
    logic [XLEN+1:0]     div_shift, div_trial;
    logic                div_borrow;

    assign div_shift  = {rem_q, quo_q[XLEN-1]};
    assign div_trial  = div_shift - {2'b00, dvsr_q};
    assign div_borrow = div_trial[XLEN+1];

    logic [2*XLEN-1:0]   prod_fix, fix_wide;
    logic [XLEN-1:0]     quo_fix, rem_fix, fix_result;

    always_comb begin
        prod_fix   = neg_q ? -acc_q : acc_q;
        quo_fix    = neg_q ? -quo_q : quo_q;
        rem_fix    = neg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
        fix_wide   = op_q[3] ? '0 : prod_fix;
        case (op_q)
            4'd0, 4'd4:             fix_result = prod_fix[XLEN-1:0];
            4'd1, 4'd2, 4'd3, 4'd5: fix_result = prod_fix[2*XLEN-1:XLEN];
            4'd8, 4'd9:             fix_result = quo_fix;
            default:                fix_result = rem_fix;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    if (!(op_is_mul || op_is_div) || early_hit)
                        state_d = DONE;
                    else if (op_is_mul)
                        state_d = MUL;
                    else
                        state_d = DIV;
                end
                MUL:  if (count_q == CW'(MUL_ITERS - 1)) state_d = FIX;
                DIV:  if (count_q == CW'(XLEN - 1)) state_d = FIX;
                FIX:  state_d = DONE;
                DONE: if (rsp_valid && rsp_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready  = (state_q == IDLE) && !flush;
        rsp_valid  = (state_q == DONE) && !flush;
        busy       = (state_q != IDLE);
        rsp_result = result_q;
        rsp_wide   = wide_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_q     <= '0;
            neg_q    <= 1'b0;
            count_q  <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            rem_q    <= '0;
            result_q <= '0;
            wide_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    op_q     <= req_op;
                    neg_q    <= neg_d;
                    count_q  <= '0;
                    mcand_q  <= {{XLEN{1'b0}}, mag1};
                    mplier_q <= mag2;
                    acc_q    <= '0;
                    quo_q    <= mag1;
                    dvsr_q   <= mag2;
                    rem_q    <= '0;
                    if (!(op_is_mul || op_is_div)) begin
                        result_q <= '0;
                        wide_q   <= '0;
                    end else if (early_hit) begin
                        result_q <= early_res;
                        wide_q   <= '0;
                    end
                end
                MUL: begin
                    acc_q    <= mul_sum;
                    mcand_q  <= mcand_q << MUL_BPC;
                    mplier_q <= mplier_q >> MUL_BPC;
                    count_q  <= count_q + CW'(1);
                end
                DIV: begin
                    rem_q   <= div_borrow ? div_shift[XLEN:0] : div_trial[XLEN:0];
                    quo_q   <= {quo_q[XLEN-2:0], ~div_borrow};
                    count_q <= count_q + CW'(1);
                end
                FIX: begin
                    result_q <= fix_result;
                    wide_q   <= fix_wide;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_xc_malu_mdr_seq.sv
// Directed bench for xc_malu_mdr_seq: mul/div vectors, multi-BPC clmulh, back-pressure, flush, reset.
module tb_xc_malu_mdr_seq;

    logic        clock = 1'b0;
    logic        reset, flush, req_valid, req_valid_b2, req_valid_b4, rsp_ready;
    logic [3:0]  req_op;
    logic [31:0] req_rs1, req_rs2;

    logic        req_ready, rsp_valid, busy;
    logic [31:0] rsp_result;
    logic [63:0] rsp_wide;
    logic        req_ready_b2, rsp_valid_b2, busy_b2;
    logic [31:0] rsp_result_b2;
    logic [63:0] rsp_wide_b2;
    logic        req_ready_b4, rsp_valid_b4, busy_b4;
    logic [31:0] rsp_result_b4;
    logic [63:0] rsp_wide_b4;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    xc_malu_mdr_seq #(.XLEN(32), .MUL_BPC(1)) u_dut (
        .clock(clock), .reset(reset), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_rs1(req_rs1), .req_rs2(req_rs2), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_wide(rsp_wide), .busy(busy)
    );

    xc_malu_mdr_seq #(.XLEN(32), .MUL_BPC(2)) u_dut_b2 (
        .clock(clock), .reset(reset), .flush(flush), .req_valid(req_valid_b2), .req_ready(req_ready_b2),
        .req_op(req_op), .req_rs1(req_rs1), .req_rs2(req_rs2), .rsp_valid(rsp_valid_b2),
        .rsp_ready(rsp_ready), .rsp_result(rsp_result_b2), .rsp_wide(rsp_wide_b2), .busy(busy_b2)
    );

    xc_malu_mdr_seq #(.XLEN(32), .MUL_BPC(4)) u_dut_b4 (
        .clock(clock), .reset(reset), .flush(flush), .req_valid(req_valid_b4), .req_ready(req_ready_b4),
        .req_op(req_op), .req_rs1(req_rs1), .req_rs2(req_rs2), .rsp_valid(rsp_valid_b4),
        .rsp_ready(rsp_ready), .rsp_result(rsp_result_b4), .rsp_wide(rsp_wide_b4), .busy(busy_b4)
    );

    function automatic int exp_edge(input int iters, input bit early_ok);
`ifdef XC_MALU_MDR_EARLY_OUT_EN
        if (early_ok) return 1;
`endif
        return iters + 2;
    endfunction

    // Presents one request on u_dut; edge 1 is the accepting edge. Returns the first edge with rsp_valid, or -1.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int edge_n);
        @(negedge clock);
        req_op = op; req_rs1 = a; req_rs2 = b; req_valid = 1'b1;
        edge_n = -1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clock); #1;
            req_valid = 1'b0;
            if (rsp_valid) begin
                edge_n = n;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; flush = 1'b0; rsp_ready = 1'b1;
        req_valid = 1'b0; req_valid_b2 = 1'b0; req_valid_b4 = 1'b0;
        req_op = '0; req_rs1 = '0; req_rs2 = '0;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (rsp_result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", rsp_result); end
        checks++; if (rsp_wide !== 64'h0) begin errors++; $display("FAIL reset_wide got %h want 0", rsp_wide); end
        @(negedge clock); reset = 1'b0;
    endtask

    task automatic test_mul;
        logic [3:0]  t_op[10]   = '{4'd2, 4'd0, 4'd3, 4'd1, 4'd1, 4'd0, 4'd4, 4'd5, 4'd6, 4'd3};
        logic [31:0] t_a[10]    = '{32'hFFFFFFFE, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000,
                                    32'h00001234, 32'h80000001, 32'd3, 32'h12345678, 32'h00000000};
        logic [31:0] t_b[10]    = '{32'd3, 32'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2,
                                    32'd0, 32'h80000001, 32'd3, 32'h9ABCDEF0, 32'h55555555};
        logic [31:0] t_res[10]  = '{32'hFFFFFFFF, 32'd42, 32'hFFFFFFFE, 32'h0, 32'hFFFFFFFF,
                                    32'h0, 32'h00000001, 32'h0, 32'h0, 32'h0};
        logic [63:0] t_wide[10] = '{64'hFFFFFFFF_FFFFFFFA, 64'd42, 64'hFFFFFFFE_00000001, 64'd1,
                                    64'hFFFFFFFF_00000000, 64'h0, 64'h40000000_00000001, 64'd5, 64'h0, 64'h0};
        bit          t_early[10] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 1};
        int          t_iters[10] = '{32, 32, 32, 32, 32, 32, 32, 32, -1, 32};
        int          e, exp_e;
        for (int i = 0; i < 10; i++) begin
            issue(t_op[i], t_a[i], t_b[i], e);
            exp_e = (t_iters[i] < 0) ? 1 : exp_edge(t_iters[i], t_early[i]);
            checks++; if (e !== exp_e) begin errors++; $display("FAIL mul_edge[%0d] got %0d want %0d", i, e, exp_e); end
            checks++; if (rsp_result !== t_res[i]) begin errors++; $display("FAIL mul_result[%0d] got %h want %h", i, rsp_result, t_res[i]); end
            checks++; if (rsp_wide !== t_wide[i]) begin errors++; $display("FAIL mul_wide[%0d] got %h want %h", i, rsp_wide, t_wide[i]); end
            @(posedge clock); #1;
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mul_return_idle[%0d] got busy %b want 0", i, busy); end
        end
    endtask

    task automatic test_div;
        logic [3:0]  t_op[13]  = '{4'd8, 4'd10, 4'd9, 4'd11, 4'd8, 4'd10, 4'd8, 4'd10, 4'd9, 4'd11, 4'd9, 4'd11, 4'd8};
        logic [31:0] t_a[13]   = '{32'h80000000, 32'h80000000, 32'd7, 32'd7, 32'hFFFFFFF9, 32'hFFFFFFF9,
                                   32'hFFFFFFF9, 32'hFFFFFFF9, 32'd5, 32'd5, 32'd100, 32'd100, 32'd7};
        logic [31:0] t_b[13]   = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd2, 32'd2,
                                   32'd0, 32'd0, 32'd9, 32'd9, 32'd7, 32'd7, 32'hFFFFFFFE};
        logic [31:0] t_res[13] = '{32'h80000000, 32'h0, 32'hFFFFFFFF, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF,
                                   32'hFFFFFFFF, 32'hFFFFFFF9, 32'd0, 32'd5, 32'd14, 32'd2, 32'hFFFFFFFD};
        bit          t_early[13] = '{0, 0, 1, 1, 0, 0, 1, 1, 1, 1, 0, 0, 0};
        int          e, exp_e;
        for (int i = 0; i < 13; i++) begin
            issue(t_op[i], t_a[i], t_b[i], e);
            exp_e = exp_edge(32, t_early[i]);
            checks++; if (e !== exp_e) begin errors++; $display("FAIL div_edge[%0d] got %0d want %0d", i, e, exp_e); end
            checks++; if (rsp_result !== t_res[i]) begin errors++; $display("FAIL div_result[%0d] got %h want %h", i, rsp_result, t_res[i]); end
            checks++; if (rsp_wide !== 64'h0) begin errors++; $display("FAIL div_wide[%0d] got %h want 0", i, rsp_wide); end
            @(posedge clock);
        end
    endtask

    task automatic test_clmul_bpc;
        int e1 = -1, e2 = -1, e4 = -1;
        logic [31:0] r1 = '0, r2 = '0, r4 = '0;
        logic [63:0] w1 = '0, w2 = '0, w4 = '0;
        @(negedge clock);
        req_op = 4'd5; req_rs1 = 32'h80000001; req_rs2 = 32'h80000001;
        req_valid = 1'b1; req_valid_b2 = 1'b1; req_valid_b4 = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clock); #1;
            req_valid = 1'b0; req_valid_b2 = 1'b0; req_valid_b4 = 1'b0;
            if (rsp_valid && e1 < 0) begin e1 = n; r1 = rsp_result; w1 = rsp_wide; end
            if (rsp_valid_b2 && e2 < 0) begin e2 = n; r2 = rsp_result_b2; w2 = rsp_wide_b2; end
            if (rsp_valid_b4 && e4 < 0) begin e4 = n; r4 = rsp_result_b4; w4 = rsp_wide_b4; end
        end
        checks++; if (e1 !== 34) begin errors++; $display("FAIL clmulh_bpc1_edge got %0d want 34", e1); end
        checks++; if (e2 !== 18) begin errors++; $display("FAIL clmulh_bpc2_edge got %0d want 18", e2); end
        checks++; if (e4 !== 10) begin errors++; $display("FAIL clmulh_bpc4_edge got %0d want 10", e4); end
        checks++; if (r1 !== 32'h40000000) begin errors++; $display("FAIL clmulh_bpc1_result got %h want 40000000", r1); end
        checks++; if (r2 !== 32'h40000000) begin errors++; $display("FAIL clmulh_bpc2_result got %h want 40000000", r2); end
        checks++; if (r4 !== 32'h40000000) begin errors++; $display("FAIL clmulh_bpc4_result got %h want 40000000", r4); end
        checks++; if (w1 !== 64'h40000000_00000001) begin errors++; $display("FAIL clmulh_bpc1_wide got %h", w1); end
        checks++; if (w2 !== 64'h40000000_00000001) begin errors++; $display("FAIL clmulh_bpc2_wide got %h", w2); end
        checks++; if (w4 !== 64'h40000000_00000001) begin errors++; $display("FAIL clmulh_bpc4_wide got %h", w4); end
    endtask

    task automatic test_back_pressure;
        int e;
        rsp_ready = 1'b0;
        issue(4'd0, 32'd7, 32'd6, e);
        checks++; if (e !== 34) begin errors++; $display("FAIL bp_edge got %0d want 34", e); end
        for (int k = 0; k < 5; k++) begin
            @(posedge clock); #1;
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d] got %b want 1", k, rsp_valid); end
            checks++; if (rsp_result !== 32'd42) begin errors++; $display("FAIL bp_hold_result[%0d] got %h want 2a", k, rsp_result); end
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_req_ready[%0d] got %b want 0", k, req_ready); end
        end
        @(negedge clock);
        rsp_ready = 1'b1;
        req_op = 4'd0; req_rs1 = 32'd9; req_rs2 = 32'd9; req_valid = 1'b1;
        @(posedge clock); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_release_busy got %b want 0", busy); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_release_req_ready got %b want 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release_rsp_valid got %b want 0", rsp_valid); end
        issue(4'd0, 32'd9, 32'd9, e);
        checks++; if (e !== 34) begin errors++; $display("FAIL bp_next_edge got %0d want 34", e); end
        checks++; if (rsp_result !== 32'd81) begin errors++; $display("FAIL bp_next_result got %h want 51", rsp_result); end
        @(posedge clock);
    endtask

    task automatic test_flush;
        int seen = 0;
        @(negedge clock);
        req_op = 4'd9; req_rs1 = 32'd100; req_rs2 = 32'd7; req_valid = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clock); #1;
            req_valid = 1'b0;
            if (n == 9) flush = 1'b1;
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", busy); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL flush_rsp_valid got %b want 0", rsp_valid); end
        flush = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clock); #1;
            if (rsp_valid) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL flush_no_response got %0d valid cycles want 0", seen); end
        @(negedge clock);
        flush = 1'b1; req_op = 4'd0; req_rs1 = 32'd3; req_rs2 = 32'd3; req_valid = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL flush_mask_req_ready got %b want 0", req_ready); end
        @(posedge clock); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_mask_accept got busy %b want 0", busy); end
        flush = 1'b0; req_valid = 1'b0;
    endtask

    task automatic test_reset_mid;
        int seen = 0;
        @(negedge clock);
        req_op = 4'd0; req_rs1 = 32'd7; req_rs2 = 32'd6; req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clock);
        #3;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy_before got %b want 1", busy); end
        reset = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_req_ready got %b want 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_rsp_valid got %b want 0", rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", busy); end
        checks++; if (rsp_result !== 32'h0) begin errors++; $display("FAIL rst_mid_result got %h want 0", rsp_result); end
        checks++; if (rsp_wide !== 64'h0) begin errors++; $display("FAIL rst_mid_wide got %h want 0", rsp_wide); end
        @(negedge clock); reset = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clock); #1;
            if (rsp_valid) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rst_mid_no_response got %0d valid cycles want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_clmul_bpc();
        test_back_pressure();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xc_malu_mdr_seq.md
Name: xc_malu_mdr_seq

Overview:
- Self-contained, parametrised iterative multiply/divide/remainder unit.
- It owns its own counter, accumulator and argument registers, so the parent no longer supplies count/acc/arg state or a shared packed adder.
- Sits in the MALU slot of the core, with valid/ready request and response handshakes.
- Adds configurable width, configurable multiply bits-per-cycle, an explicit sign-fixup stage and response back-pressure.

Parameters:
- XLEN, 32: operand width; must be even and at least 8.
- MUL_BPC, 1: multiplier bits retired per cycle (1, 2 or 4); must divide XLEN.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  abort current operation, return to IDLE
- req_valid  in  1  request valid
- req_ready  out  1  high only in IDLE
- req_op  in  4  0 mul, 1 mulh, 2 mulhsu, 3 mulhu, 4 clmul, 5 clmulh, 8 div, 9 divu, 10 rem, 11 remu; other codes reserved
- req_rs1  in  XLEN  lhs / dividend
- req_rs2  in  XLEN  rhs / divisor
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_result  out  XLEN  selected result
- rsp_wide  out  2*XLEN  full product {hi,lo}; zero for div/rem
- busy  out  1  state != IDLE

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; all datapath registers 0.
  - req_ready=1, rsp_valid=0, busy=0, rsp_result=0, rsp_wide=0.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE:
  - Accept on req_valid&&req_ready.
  - Latch op.
  - Latch operand magnitudes: absolute value of signed operands per op; clmul uses operands unchanged.
  - Latch result-sign flags.
  - count=0. Go to MUL for ops 0-5, DIV for ops 8-11.
  - Reserved op: go directly to DONE with result 0 next cycle.
- MUL:
  - Each cycle, examine MUL_BPC low bits of the shifted multiplier.
  - Add the shifted multiplicand into the 2*XLEN accumulator: carry-save-free add for arithmetic ops, XOR for clmul ops.
  - Shift the multiplier right by MUL_BPC; count+=1.
  - After XLEN/MUL_BPC cycles go to FIX.
- DIV:
  - Radix-2 restoring division, one quotient bit per cycle, XLEN cycles, then FIX.
  - Remainder register is XLEN+1 bits wide to hold the trial-subtract borrow.
- FIX (one cycle):
  - Apply negation where the result sign is set: two's complement of the 2*XLEN product, quotient or remainder.
  - Register outputs; go to DONE.
- Sign rules:
  - mulh: both operands signed.
  - mulhsu: rs1 signed, rs2 unsigned.
  - div: quotient negative iff signs differ and rs2!=0.
  - rem: remainder takes the sign of rs1.
- Divide by zero: quotient all ones, remainder = rs1, for both signed and unsigned.
- Signed overflow (MIN / -1): quotient MIN, remainder 0; this must fall out of the magnitude path.
- rsp_result selection:
  - low half for mul/clmul.
  - high half for mulh/mulhsu/mulhu/clmulh.
  - quotient for div/divu; remainder for rem/remu.
- DONE:
  - rsp_valid=1, outputs held stable until rsp_ready.
  - On rsp_valid&&rsp_ready go to IDLE; the next request can be accepted on the following cycle (no same-cycle reissue).
- Latency: rsp_valid rises ITERS+2 rising edges after the accepting edge.
  - ITERS = XLEN/MUL_BPC for multiply ops, XLEN for divide ops.
  - With defaults: multiply 34 edges, divide 34 edges.
- flush:
  - Highest priority in every state: next state IDLE, rsp_valid=0, request dropped.
  - If flush and req_valid are both high in IDLE, the request is not accepted and req_ready is masked low.
- reset mid-operation: immediate return to the reset state; no response is produced.

Optional Feature:
- Macro: XC_MALU_MDR_EARLY_OUT_EN.
- When defined, IDLE detects these cases:
  - divide by zero;
  - multiply with either operand zero;
  - divide where |rs2| > |rs1| (unsigned compare of magnitudes).
- On detection, the unit skips compute and FIX and goes directly to DONE with the architecturally correct result, so rsp_valid rises 1 edge after accept.
- When not defined, every op takes the full latency and results are identical.

Test Plan:
- mulhsu, XLEN=32, MUL_BPC=1: rs1=0xFFFFFFFE (-2), rs2=0x00000003 -> rsp_result=0xFFFFFFFF, rsp_wide=0xFFFFFFFF_FFFFFFFA; rsp_valid at edge 34.
- div: rs1=0x80000000, rs2=0xFFFFFFFF -> result 0x80000000. rem with the same operands -> 0. divu 7/0 -> 0xFFFFFFFF. remu 7/0 -> 7.
- clmulh: rs1=0x80000001, rs2=0x80000001 -> rsp_wide=0x40000000_00000001, rsp_result=0x40000000. Run at MUL_BPC=1, 2 and 4; rsp_valid at edges 34, 18 and 10 respectively.
- Hold rsp_ready=0 for 5 cycles in DONE -> rsp_valid and result stable, req_ready=0. Release -> IDLE next cycle and a new request is accepted.
- Assert flush at edge 10 of a div -> IDLE next cycle, no rsp_valid. Assert reset mid-mul -> all outputs at reset values immediately.
- With XC_MALU_MDR_EARLY_OUT_EN: divu 5/9 -> quotient 0 at edge 1; mul x*0 -> 0 at edge 1. Without the macro, the same operands give identical values at edge 34.
